// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and constants for the instruction loader
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_FLUSH,
        S_RUN,
        S_ERROR
    } state_e;

    localparam logic [5:0] OPC_HALT  = 6'b111111;
    localparam int         ADDR_STEP = 4;

endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: packs accepted bytes big-endian into one instruction word
module byte_assembler #(
    parameter int NB_WORD = 32
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [7:0]         i_byte,
    output logic [NB_WORD-1:0] o_word,
    output logic               o_word_valid
);

    localparam int NBYTES = NB_WORD / 8;
    localparam int BW     = NBYTES > 1 ? $clog2(NBYTES) : 1;

    logic [NB_WORD-9:0] shift_q;
    logic [BW-1:0]      cnt_q;

    // the completed word includes the byte being accepted right now
    always_comb begin
        o_word       = {shift_q, i_byte};
        o_word_valid = i_valid & (cnt_q == BW'(NBYTES - 1));
    end

    // shift earlier bytes toward the MSB; a clear discards a partial word
    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_valid) begin
            shift_q <= o_word[NB_WORD-9:0];
            cnt_q   <= o_word_valid ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: streams bytes into instruction memory, then releases the pipeline
module instruction_loader
    import loader_pkg::*;
#(
    parameter int                  NB_DATA    = 32,
    parameter int                  NB_ADDR    = 32,
    parameter logic [NB_ADDR-1:0]  BASE_ADDR  = '0,
    parameter int                  MAX_WORDS  = 64,
    parameter int                  RST_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_byte_valid,
    input  logic [7:0]                     i_byte_data,
    output logic                           o_byte_ready,
    output logic                           o_we_IF,
    output logic [NB_DATA-1:0]             o_instruction_data,
    output logic [NB_ADDR-1:0]             o_inst_addr,
    output logic                           o_halt,
    output logic                           o_pipe_rst_n,
    output logic [$clog2(MAX_WORDS+1)-1:0] o_word_count,
    output logic                           o_done,
    output logic                           o_error
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int FW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;

    state_e             state_q, state_d;
    logic               ready_q, we_q, halt_q, rst_n_q, done_q, error_q;
    logic [NB_DATA-1:0] data_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [CW-1:0]      count_q, count_inc;
    logic [FW-1:0]      flush_q;
    logic               accept, restart, word_valid;
    logic [NB_DATA-1:0] word;

    // a byte moves only when ready was registered high; a restart is only legal when not loading
    always_comb begin
        accept    = i_byte_valid & ready_q;
        restart   = i_start & (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERROR);
        count_inc = count_q + 1'b1;
    end

    byte_assembler #(
        .NB_WORD(NB_DATA)
    ) u_asm (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_clear     (restart),
        .i_valid     (accept),
        .i_byte      (i_byte_data),
        .o_word      (word),
        .o_word_valid(word_valid)
    );

    // next state; HALT takes precedence over the capacity check
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: state_d = i_start ? S_RECV : state_q;
            S_RECV:  state_d = word_valid ? S_WRITE : S_RECV;
            S_WRITE: state_d = data_q[NB_DATA-1 -: 6] == OPC_HALT ? S_FLUSH :
                               count_inc == CW'(MAX_WORDS) ? S_ERROR : S_RECV;
            S_FLUSH: state_d = flush_q == FW'(RST_CYCLES - 1) ? S_RUN : S_FLUSH;
            default: state_d = S_IDLE;
        endcase
    end

    // state, counters and outputs registered from the next state so no output sees an input
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            halt_q  <= 1'b1;
            rst_n_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= state_d == S_RECV;
            we_q    <= state_d == S_WRITE;
            halt_q  <= state_d != S_RUN;
            rst_n_q <= state_d == S_RUN;
            done_q  <= state_d == S_RUN;
            error_q <= state_d == S_ERROR;
            flush_q <= state_q == S_FLUSH ? flush_q + 1'b1 : '0;
            if (word_valid) data_q <= word;
            if (restart) begin
                addr_q  <= BASE_ADDR;
                count_q <= '0;
            end else if (state_q == S_WRITE) begin
                addr_q  <= addr_q + NB_ADDR'(ADDR_STEP);
                count_q <= count_inc;
            end
        end
    end

    assign o_byte_ready       = ready_q;
    assign o_we_IF            = we_q;
    assign o_instruction_data = data_q;
    assign o_inst_addr        = addr_q;
    assign o_halt             = halt_q;
    assign o_pipe_rst_n       = rst_n_q;
    assign o_word_count       = count_q;
    assign o_done             = done_q;
    assign o_error            = error_q;

endmodule
